// File: rtl/reset_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_pkg;

   typedef enum logic [1:0] {
      S_HOLD,
      S_SEQ,
      S_DONE,
      S_SWHOLD
   } rst_state_e;

   // The shared counter must reach the larger of the two terminal counts.
   function automatic int cnt_width(input int gap_cycles, input int swrst_hold);
      int max_val;
      max_val = (gap_cycles > swrst_hold) ? gap_cycles : swrst_hold;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert chain: RST_N low clears every flop at once,
// release ripples a 1 through SYNC_DEPTH flops.
module reset_sync #(
   parameter int SYNC_DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic sync_n,
   output logic sync_next_n
);

   logic [SYNC_DEPTH-1:0] chain_q;
   logic [SYNC_DEPTH-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[SYNC_DEPTH-2:0], 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   // sync_next_n already sits behind SYNC_DEPTH-1 flops; it is the value
   // sync_n takes on the coming edge.
   assign sync_n      = chain_q[SYNC_DEPTH-1];
   assign sync_next_n = chain_q[SYNC_DEPTH-2];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered release of STAGES downstream resets after power-up or a software
// reset request; all outputs come straight from flops.
module reset_sequencer
   import reset_pkg::*;
#(
   parameter int STAGES     = 3,
   parameter int GAP_CYCLES = 16,
   parameter int SYNC_DEPTH = 2,
   parameter int SWRST_HOLD = 256
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              SWRST_REQ,
   output logic [STAGES-1:0] STAGE_RST_N,
   output logic              READY,
   output logic              BUSY,
   output rst_state_e        dbg_state,
   output logic              dbg_sync_n
);

   localparam int CW = cnt_width(GAP_CYCLES, SWRST_HOLD);
   localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;

   logic sync_n;
   logic sync_next_n;

   rst_state_e        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [STAGES-1:0] stage_q, stage_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;

   reset_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
      .clk         (CLK),
      .rst_n       (RST_N),
      .sync_n      (sync_n),
      .sync_next_n (sync_next_n)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      stage_d = stage_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      case (state_q)
         // Leave on the same edge that raises sync_n so the first gap is
         // counted from that edge.
         S_HOLD: begin
            if (sync_next_n) begin
               state_d = S_SEQ;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         S_SEQ: begin
            if (cnt_q == CW'(GAP_CYCLES - 1)) begin
               cnt_d = '0;
               for (int k = 0; k < STAGES; k++) begin
                  if (idx_q == IW'(k)) stage_d[k] = 1'b1;
               end
               if (idx_q == IW'(STAGES - 1)) begin
                  state_d = S_DONE;
                  idx_d   = '0;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            if (SWRST_REQ) begin
               state_d = S_SWHOLD;
               cnt_d   = '0;
               stage_d = '0;
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_SWHOLD: begin
            if (cnt_q == CW'(SWRST_HOLD - 1)) begin
               state_d = S_SEQ;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            stage_d = '0;
            ready_d = 1'b0;
            busy_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         stage_q <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stage_q <= stage_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign STAGE_RST_N = stage_q;
   assign READY       = ready_q;
   assign BUSY        = busy_q;
   assign dbg_state   = state_q;
   assign dbg_sync_n  = sync_n;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance and a minimal
// STAGES=1/GAP_CYCLES=1 instance share clock, reset and request stimulus.
module tb_reset_sequencer;
   import reset_pkg::*;

   localparam int B_ST = 3, B_GAP = 16, B_SD = 2, B_HOLD = 256;
   localparam int S_ST = 1, S_GAP = 1,  S_SD = 2, S_HOLD = 5;

   logic             CLK;
   logic             RST_N;
   logic             SWRST_REQ;
   logic [B_ST-1:0]  b_stage;
   logic             b_ready, b_busy, b_sync;
   rst_state_e       b_state;
   logic [S_ST-1:0]  s_stage;
   logic             s_ready, s_busy, s_sync;
   rst_state_e       s_state;

   int n_checks = 0;
   int n_pass   = 0;

   // model: edges since the last RST_N release, plus the start edge and
   // lead-in of the sequence currently running in each instance
   int m_n = 0;
   int b_base = 0, b_off = B_SD;
   int s_base = 0, s_off = S_SD;

   reset_sequencer u_big (
      .CLK(CLK), .RST_N(RST_N), .SWRST_REQ(SWRST_REQ),
      .STAGE_RST_N(b_stage), .READY(b_ready), .BUSY(b_busy),
      .dbg_state(b_state), .dbg_sync_n(b_sync)
   );

   reset_sequencer #(
      .STAGES(S_ST), .GAP_CYCLES(S_GAP), .SYNC_DEPTH(S_SD), .SWRST_HOLD(S_HOLD)
   ) u_small (
      .CLK(CLK), .RST_N(RST_N), .SWRST_REQ(SWRST_REQ),
      .STAGE_RST_N(s_stage), .READY(s_ready), .BUSY(s_busy),
      .dbg_state(s_state), .dbg_sync_n(s_sync)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // stage k is released once (edges since sequence start) >= off + (k+1)*gap
   function automatic logic [7:0] exp_stages(input int n, input int base,
                                             input int off, input int gap,
                                             input int stages);
      logic [7:0] r;
      r = '0;
      for (int k = 0; k < stages; k++) r[k] = ((n - base) >= off + (k + 1) * gap);
      return r;
   endfunction

   function automatic logic exp_ready(input int n, input int base, input int off,
                                      input int gap, input int stages);
      return (n - base) >= off + stages * gap;
   endfunction

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_n    <= 0;
         b_base <= 0;
         b_off  <= B_SD;
         s_base <= 0;
         s_off  <= S_SD;
      end else begin
         m_n <= m_n + 1;
         if (SWRST_REQ && exp_ready(m_n, b_base, b_off, B_GAP, B_ST)) begin
            b_base <= m_n + 1;
            b_off  <= B_HOLD;
         end
         if (SWRST_REQ && exp_ready(m_n, s_base, s_off, S_GAP, S_ST)) begin
            s_base <= m_n + 1;
            s_off  <= S_HOLD;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)",
                    name, got, exp, m_n, $time);
   endtask

   // scoreboard compare, every cycle, away from the active edge
   always @(negedge CLK) begin
      logic [7:0] eb, es;
      logic rb, rs;
      eb = exp_stages(m_n, b_base, b_off, B_GAP, B_ST);
      es = exp_stages(m_n, s_base, s_off, S_GAP, S_ST);
      rb = exp_ready(m_n, b_base, b_off, B_GAP, B_ST);
      rs = exp_ready(m_n, s_base, s_off, S_GAP, S_ST);
      check("big_stage", 32'(b_stage), 32'(eb[B_ST-1:0]));
      check("big_ready", 32'(b_ready), 32'(rb));
      check("big_busy",  32'(b_busy),  32'(!rb));
      check("big_done_state", 32'(b_state == S_DONE), 32'(rb));
      check("big_sync", 32'(b_sync), 32'(m_n >= B_SD));
      check("small_stage", 32'(s_stage), 32'(es[S_ST-1:0]));
      check("small_ready", 32'(s_ready), 32'(rs));
      check("small_busy",  32'(s_busy),  32'(!rs));
      check("small_done_state", 32'(s_state == S_DONE), 32'(rs));
      check("small_sync", 32'(s_sync), 32'(m_n >= S_SD));
   end

   // driver tasks
   task automatic wait_edge(input int target);
      int guard;
      guard = 0;
      while (m_n < target && guard < 3000) begin
         @(posedge CLK);
         #1;
         guard++;
      end
      if (m_n != target) begin
         n_checks++;
         $display("FAIL wait_edge: reached edge %0d, wanted %0d", m_n, target);
      end
   endtask

   task automatic pulse_swrst();
      @(posedge CLK);
      #2 SWRST_REQ = 1'b1;
      @(posedge CLK);
      #2 SWRST_REQ = 1'b0;
   endtask

   task automatic reset_cycles(input int cycles);
      @(posedge CLK);
      #2 RST_N = 1'b0;
      repeat (cycles) @(posedge CLK);
      #2 RST_N = 1'b1;
   endtask

   task automatic glitch(input int width);
      @(posedge CLK);
      #3 RST_N = 1'b0;
      #1;
      check("glitch_stage", 32'(b_stage), 32'd0);
      check("glitch_ready", 32'(b_ready), 32'd0);
      check("glitch_busy",  32'(b_busy),  32'd1);
      check("glitch_small", 32'({s_stage, s_ready, s_busy}), 32'b001);
      #(width) RST_N = 1'b1;
   endtask

   initial begin
      int e;
      RST_N     = 1'b0;
      SWRST_REQ = 1'b0;

      // power-up
      repeat (5) @(posedge CLK);
      #1;
      check("reset_stage", 32'(b_stage), 32'd0);
      check("reset_busy",  32'(b_busy),  32'd1);
      #1 RST_N = 1'b1;
      wait_edge(2);  check("small_e2",  32'({s_stage, s_ready}), 32'b00);
      wait_edge(3);  check("small_e3",  32'({s_stage, s_ready}), 32'b11);
      wait_edge(17); check("big_e17", 32'(b_stage), 32'b000);
      wait_edge(18); check("big_e18", 32'(b_stage), 32'b001);
      wait_edge(34); check("big_e34", 32'(b_stage), 32'b011);
      wait_edge(49); check("big_e49", 32'({b_ready, b_busy}), 32'b01);
      wait_edge(50); check("big_e50", 32'({b_stage, b_ready, b_busy}), 32'b11110);

      // async assert in S_DONE via a sub-cycle glitch
      wait_edge(60);
      glitch(2);
      wait_edge(18); check("reglitch_e18", 32'(b_stage), 32'b001);
      wait_edge(50); check("reglitch_e50", 32'(b_ready), 32'd1);

      // software reset
      wait_edge(55);
      pulse_swrst();
      e = m_n;
      #1;
      check("swrst_drop", 32'({b_stage, b_ready, b_busy}), 32'b00001);
      wait_edge(e + 271); check("swrst_271", 32'(b_stage), 32'b000);
      wait_edge(e + 272); check("swrst_272", 32'(b_stage), 32'b001);
      wait_edge(e + 303); check("swrst_303", 32'(b_ready), 32'd0);
      wait_edge(e + 304); check("swrst_304", 32'({b_stage, b_ready}), 32'b1111);

      // request during S_SEQ is ignored
      reset_cycles(1);
      wait_edge(25);
      pulse_swrst();
      wait_edge(34); check("ignored_e34", 32'(b_stage), 32'b011);
      wait_edge(49); check("ignored_busy", 32'(b_busy), 32'd1);
      wait_edge(50); check("ignored_e50", 32'({b_ready, b_busy}), 32'b10);

      // reset mid-sequence while stage 0 is released
      reset_cycles(1);
      wait_edge(20); check("mid_pre", 32'(b_stage), 32'b001);
      reset_cycles(1);
      wait_edge(17); check("mid_e17", 32'(b_stage), 32'b000);
      wait_edge(18); check("mid_e18", 32'(b_stage), 32'b001);
      wait_edge(50); check("mid_e50", 32'(b_stage), 32'b111);

      // randomized mix of requests, glitches and reset pulses
      for (int it = 0; it < 25; it++) begin
         repeat ($urandom_range(0, 350)) @(posedge CLK);
         case ($urandom_range(0, 2))
            0: pulse_swrst();
            1: glitch($urandom_range(1, 5));
            default: reset_cycles($urandom_range(1, 4));
         endcase
      end
      repeat (400) @(posedge CLK);
      @(negedge CLK);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
